// File: rtl/irq_sched_pkg.sv
// Shared definitions for the interrupt scheduler: FSM encoding, miss counter width
// and a saturating increment used by the miss counter.
package irq_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARB     = 2'd1,
        ST_PRESENT = 2'd2,
        ST_SERVICE = 2'd3
    } state_t;

    localparam int MISS_W = 8;

    function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
        return (v == {MISS_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/irq_rr_pick.sv
// Combinational rotating-priority picker: lowest set req index strictly after ptr, wrapping.
// Zero latency; no flow control, any=0 when req is empty.
module irq_rr_pick #(
    parameter int DATAWIDTH = 8,
    parameter int VECWIDTH  = 3
) (
    input  logic [DATAWIDTH-1:0] req,
    input  logic [VECWIDTH-1:0]  ptr,
    output logic [VECWIDTH-1:0]  grant,
    output logic                 any
);

    logic [2*DATAWIDTH-1:0] dbl;
    logic [DATAWIDTH-1:0]   rot;
    int unsigned            base;

    // Rotate so the search start lands at bit 0, then take the lowest set bit.
    always_comb begin
        base  = (32'(ptr) + 32'd1) % 32'(DATAWIDTH);
        dbl   = {req, req} >> base;
        rot   = dbl[DATAWIDTH-1:0];
        any   = |req;
        grant = '0;
        for (int j = DATAWIDTH - 1; j >= 0; j--) begin
            if (rot[j]) begin
                grant = VECWIDTH'((base + 32'(j)) % 32'(DATAWIDTH));
            end
        end
    end

endmodule

// File: rtl/irq_sched.sv
// Non-nested vectored interrupt scheduler: round-robin pick, present to CPU, track in-service until EOI.
// irq_out_l falls two edges after pending appears; a request not acked within TIMEOUT clocks is withdrawn.
module irq_sched
    import irq_sched_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int VECWIDTH  = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic                 bus_clk,
    input  logic                 bus_reset,
    input  logic [DATAWIDTH-1:0] irqs_in_l,
    input  logic [DATAWIDTH-1:0] irq_en,
    input  logic                 irq_ack,
    input  logic                 irq_eoi,
    output logic                 irq_out_l,
    output logic [VECWIDTH-1:0]  irq_vec,
    output logic [DATAWIDTH-1:0] in_service,
    output logic [MISS_W-1:0]    miss_count
);

    localparam int            TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [VECWIDTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic [VECWIDTH-1:0]    vec_q, vec_d;
    logic                   irq_l_q, irq_l_d;
    logic [DATAWIDTH-1:0]   isr_q, isr_d;
    logic [MISS_W-1:0]      miss_q, miss_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [DATAWIDTH-1:0]   pending;
    logic [VECWIDTH-1:0]    pick_grant;
    logic                   pick_any;

    assign pending = ~irqs_in_l & irq_en;

    irq_rr_pick #(
        .DATAWIDTH(DATAWIDTH),
        .VECWIDTH (VECWIDTH)
    ) u_pick (
        .req  (pending),
        .ptr  (rr_ptr_q),
        .grant(pick_grant),
        .any  (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        vec_d    = vec_q;
        irq_l_d  = irq_l_q;
        isr_d    = isr_q;
        miss_d   = miss_q;
        timer_d  = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (pick_any) begin
                    vec_d   = pick_grant;
                    irq_l_d = 1'b0;
                    timer_d = '0;
                    state_d = ST_PRESENT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                // Ack beats withdrawal beats timeout; only a timeout moves the pointer.
                if (irq_ack) begin
                    irq_l_d = 1'b1;
                    isr_d   = DATAWIDTH'(1) << vec_q;
                    state_d = ST_SERVICE;
                end else if (!pending[vec_q]) begin
                    irq_l_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (timer_q == T_LAST) begin
                    irq_l_d  = 1'b1;
                    rr_ptr_d = vec_q;
                    miss_d   = sat_inc(miss_q);
                    state_d  = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_SERVICE: begin
                if (irq_eoi) begin
                    isr_d    = '0;
                    rr_ptr_d = vec_q;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge bus_clk) begin
        if (bus_reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= VECWIDTH'(DATAWIDTH - 1);
            vec_q    <= '0;
            irq_l_q  <= 1'b1;
            isr_q    <= '0;
            miss_q   <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            vec_q    <= vec_d;
            irq_l_q  <= irq_l_d;
            isr_q    <= isr_d;
            miss_q   <= miss_d;
            timer_q  <= timer_d;
        end
    end

    assign irq_out_l  = irq_l_q;
    assign irq_vec    = vec_q;
    assign in_service = isr_q;
    assign miss_count = miss_q;

endmodule

// File: tb/tb_irq_sched.sv
// Directed bench for irq_sched with TIMEOUT=4 so the withdrawal-on-timeout path is short.
module tb_irq_sched;

    logic       bus_clk = 1'b0;
    logic       bus_reset;
    logic [7:0] irqs_in_l;
    logic [7:0] irq_en;
    logic       irq_ack;
    logic       irq_eoi;
    logic       irq_out_l;
    logic [2:0] irq_vec;
    logic [7:0] in_service;
    logic [7:0] miss_count;

    int checks = 0;
    int errors = 0;

    irq_sched #(
        .DATAWIDTH(8),
        .VECWIDTH (3),
        .TIMEOUT  (4)
    ) dut (
        .bus_clk   (bus_clk),
        .bus_reset (bus_reset),
        .irqs_in_l (irqs_in_l),
        .irq_en    (irq_en),
        .irq_ack   (irq_ack),
        .irq_eoi   (irq_eoi),
        .irq_out_l (irq_out_l),
        .irq_vec   (irq_vec),
        .in_service(in_service),
        .miss_count(miss_count)
    );

    always #5 bus_clk = ~bus_clk;

    task automatic tick();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for the request line to go low.
    task automatic wait_req(input string tag);
        int n = 0;
        while (irq_out_l !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_req"}, 32'(irq_out_l), 32'd0);
    endtask

    task automatic serve(input logic [2:0] ev, input string tag);
        wait_req(tag);
        check({tag, "_vec"}, 32'(irq_vec), 32'(ev));
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check({tag, "_isr"}, 32'(in_service), 32'(8'h01 << ev));
        irq_eoi = 1'b1;
        tick();
        irq_eoi = 1'b0;
        check({tag, "_eoi"}, 32'(in_service), 32'd0);
    endtask

    initial begin
        int n;
        bus_reset = 1'b1;
        irqs_in_l = 8'hFF;
        irq_en    = 8'h00;
        irq_ack   = 1'b0;
        irq_eoi   = 1'b0;
        tick();
        tick();
        bus_reset = 1'b0;
        check("rst_out_l", 32'(irq_out_l), 32'd1);
        check("rst_vec", 32'(irq_vec), 32'd0);
        check("rst_isr", 32'(in_service), 32'd0);
        check("rst_miss", 32'(miss_count), 32'd0);

        // Single source 3: two-edge latency, ack, hold through deassertion, eoi.
        irq_en    = 8'hFF;
        irqs_in_l = 8'hF7;
        tick();
        check("t1_lat1", 32'(irq_out_l), 32'd1);
        tick();
        check("t1_lat2", 32'(irq_out_l), 32'd0);
        check("t1_vec", 32'(irq_vec), 32'd3);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t1_ack_out", 32'(irq_out_l), 32'd1);
        check("t1_isr", 32'(in_service), 32'h08);
        irqs_in_l = 8'hFF;
        tick();
        check("t1_isr_hold", 32'(in_service), 32'h08);
        irq_eoi = 1'b1;
        tick();
        irq_eoi = 1'b0;
        check("t1_eoi", 32'(in_service), 32'd0);
        check("t1_vec_hold", 32'(irq_vec), 32'd3);

        // Sources 1 and 5 with pointer at 3: 5,1,5; then add 0 -> 0,1.
        irqs_in_l = 8'hDD;
        serve(3'd5, "t2a");
        serve(3'd1, "t2b");
        serve(3'd5, "t2c");
        irqs_in_l = 8'hDC;
        serve(3'd0, "t2d");
        serve(3'd1, "t2e");
        irqs_in_l = 8'hFF;

        // Timeout on source 2: low for exactly 4 clocks, then source 6 wins.
        irqs_in_l = 8'hFB;
        wait_req("t3");
        check("t3_vec", 32'(irq_vec), 32'd2);
        n = 0;
        while (irq_out_l === 1'b0 && n < 20) begin
            tick();
            n++;
        end
        check("t3_low_clks", 32'(n), 32'd4);
        check("t3_miss", 32'(miss_count), 32'd1);
        irqs_in_l = 8'hBB;
        serve(3'd6, "t3b");
        irqs_in_l = 8'hFF;

        // Withdrawal by source deassertion, then by enable clear.
        irqs_in_l = 8'hEF;
        wait_req("t4a");
        check("t4a_vec", 32'(irq_vec), 32'd4);
        irqs_in_l = 8'hFF;
        tick();
        check("t4a_out", 32'(irq_out_l), 32'd1);
        check("t4a_isr", 32'(in_service), 32'd0);
        check("t4a_miss", 32'(miss_count), 32'd1);
        irqs_in_l = 8'hEF;
        wait_req("t4b");
        check("t4b_vec", 32'(irq_vec), 32'd4);
        irq_en = 8'hEF;
        tick();
        check("t4b_out", 32'(irq_out_l), 32'd1);
        check("t4b_isr", 32'(in_service), 32'd0);
        check("t4b_miss", 32'(miss_count), 32'd1);
        irq_en    = 8'hFF;
        irqs_in_l = 8'hFF;

        // Ack together with deassertion: ack wins.
        irqs_in_l = 8'hEF;
        wait_req("t5a");
        irq_ack   = 1'b1;
        irqs_in_l = 8'hFF;
        tick();
        irq_ack = 1'b0;
        check("t5a_isr", 32'(in_service), 32'h10);
        irq_eoi = 1'b1;
        tick();
        irq_eoi = 1'b0;
        check("t5a_eoi", 32'(in_service), 32'd0);

        // Ack on the timeout cycle: ack wins, no miss.
        irqs_in_l = 8'hFB;
        wait_req("t5b");
        tick();
        tick();
        tick();
        check("t5b_still_low", 32'(irq_out_l), 32'd0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t5b_isr", 32'(in_service), 32'h04);
        check("t5b_miss", 32'(miss_count), 32'd1);
        check("t5b_out", 32'(irq_out_l), 32'd1);
        irqs_in_l = 8'hFF;
        irq_eoi   = 1'b1;
        tick();
        irq_eoi = 1'b0;

        // Reset while in service, with eoi also asserted.
        irqs_in_l = 8'hDF;
        wait_req("t6");
        check("t6_vec", 32'(irq_vec), 32'd5);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t6_isr", 32'(in_service), 32'h20);
        bus_reset = 1'b1;
        irq_eoi   = 1'b1;
        tick();
        bus_reset = 1'b0;
        irq_eoi   = 1'b0;
        check("t6_rst_out", 32'(irq_out_l), 32'd1);
        check("t6_rst_vec", 32'(irq_vec), 32'd0);
        check("t6_rst_isr", 32'(in_service), 32'd0);
        check("t6_rst_miss", 32'(miss_count), 32'd0);

        // All sources active but masked: request never asserts.
        irqs_in_l = 8'h00;
        irq_en    = 8'h00;
        n = 0;
        repeat (100) begin
            tick();
            if (irq_out_l !== 1'b1) n++;
        end
        check("t6_masked_lows", 32'(n), 32'd0);

        // Pointer was reset to 7, so source 0 wins first.
        irq_en = 8'hFF;
        wait_req("t6b");
        check("t6b_vec", 32'(irq_vec), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
